timer_reg_arbiter: RTL

- Two-requester arbiter for the 8-bit timer's register bus; requester 0 is the CPU port, requester 1 is a secondary configuration master (e.g. an autoload sequencer).
- Round-robin selection; the winner's transaction is latched and issued as a single register-bus access.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the masters and the timer register block.

---
 rtl/timer_reg_arbiter_if.sv | 46 ++++
 rtl/timer_reg_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/timer_reg_arbiter_if.sv
// Requester, register-bus and status signals shared by the timer register arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the register block.
interface timer_reg_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic              m_err;
  logic              reg_sel;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output m_err, reg_sel, reg_wr, reg_addr, reg_wdata,
    input  reg_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  m_err, reg_sel, reg_wr, reg_addr, reg_wdata,
    output reg_rdata,
    input  busy
  );
endinterface

// File: rtl/timer_reg_arbiter.sv
// Two-master arbiter for the timer register bus: round-robin, or fixed priority to m0 with TIMER_ARB_FIXED_PRIO_EN.
// Grant edge -> reg_sel next cycle -> ack the cycle after; the loser keeps req high and waits for the next IDLE.
module timer_reg_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  timer_reg_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

  state_t            state, state_nxt;
  logic              gnt_vld, gnt_id;
  logic              sel_wr, sel_in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_cap;
  logic              win_id, err_flag;
  logic              reg_sel_q, reg_wr_q, m0_ack_q, m1_ack_q, m_err_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q, m0_rdata_q, m1_rdata_q;

`ifdef TIMER_ARB_FIXED_PRIO_EN
  always_comb gnt_id = ~bus.m0_req;
`else
  logic last_grant;

  always_comb begin
    if (bus.m0_req && bus.m1_req) gnt_id = ~last_grant;
    else                          gnt_id = bus.m1_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_grant <= 1'b1;
    else if (state == RESP) last_grant <= win_id;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          gnt_vld   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_wr       = gnt_id ? bus.m1_wr    : bus.m0_wr;
  assign sel_addr     = gnt_id ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata    = gnt_id ? bus.m1_wdata : bus.m0_wdata;
  assign sel_in_range = (sel_addr < REG_LIMIT);
  // Writes and out-of-range accesses return zero read data.
  assign rd_cap       = (reg_sel_q && !reg_wr_q) ? bus.reg_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_id      <= 1'b0;
      err_flag    <= 1'b0;
      reg_sel_q   <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m_err_q     <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      reg_sel_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m_err_q   <= 1'b0;
      if (gnt_vld) begin
        win_id      <= gnt_id;
        err_flag    <= ~sel_in_range;
        reg_sel_q   <= sel_in_range;
        reg_wr_q    <= sel_wr & sel_in_range;
        reg_addr_q  <= sel_addr;
        reg_wdata_q <= sel_wdata;
      end
      if (state == ACCESS) begin
        if (win_id) m1_rdata_q <= rd_cap;
        else        m0_rdata_q <= rd_cap;
        m0_ack_q <= ~win_id;
        m1_ack_q <= win_id;
        m_err_q  <= err_flag;
      end
    end
  end

  assign bus.reg_sel   = reg_sel_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m_err     = m_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule
